hazard_ctrl: RTL and testbench

- Pipeline control unit that drives the en/clr inputs of every inter-stage register: F (PC), F->D, D->E, E->M and M->W.
- Produces operand-forwarding selects for the execute stage.
- Resolves load-use stalls and taken-branch/jump flushes.
- Contains a sequential memory-wait FSM that freezes the pipeline while the data memory is not ready, with a watchdog timeout.

---
 rtl/pipeline_pkg.sv | 16 +
 rtl/forward_unit.sv | 28 ++
 rtl/hazard_ctrl.sv | 137 +++++++++++++
 tb/tb_hazard_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipeline_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WAIT  = 2'b01,
    ERROR = 2'b10
  } mem_state_t;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  localparam logic [1:0] RESULT_LOAD = 2'b01;

endpackage

// File: rtl/forward_unit.sv
// Operand forwarding select for one execute-stage source register.
module forward_unit
  import pipeline_pkg::*;
#(
  parameter int REGISTER_ADDRESS_WIDTH = 5
) (
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] RsE_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdM_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdW_i,
  input  logic                              RegWriteM_i,
  input  logic                              RegWriteW_i,
  output logic [1:0]                        Forward_o
);

  logic w_hit_m;
  logic w_hit_w;

  // x0 is hardwired zero, so a write to it must never be forwarded
  assign w_hit_m = RegWriteM_i && (RdM_i != '0) && (RdM_i == RsE_i);
  assign w_hit_w = RegWriteW_i && (RdW_i != '0) && (RdW_i == RsE_i);

  always_comb begin
    Forward_o = FWD_RF;
    if (w_hit_m)      Forward_o = FWD_M;
    else if (w_hit_w) Forward_o = FWD_W;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding, load-use stall, branch flush and
// a memory-wait FSM with watchdog that freezes the whole pipeline.
module hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int REGISTER_ADDRESS_WIDTH = 5,
  parameter int MAX_WAIT               = 16,
  parameter int CNT_WIDTH              = 5
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs1D_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs2D_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs1E_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs2E_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdE_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdM_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdW_i,
  input  logic                              RegWriteM_i,
  input  logic                              RegWriteW_i,
  input  logic [1:0]                        ResultSrcE_i,
  input  logic                              PCSrcE_i,
  input  logic                              MemReqM_i,
  input  logic                              MemReadyM_i,
  output logic                              EnF_o,
  output logic                              EnD_o,
  output logic                              EnE_o,
  output logic                              EnM_o,
  output logic                              ClrD_o,
  output logic                              ClrE_o,
  output logic                              ClrW_o,
  output logic [1:0]                        ForwardAE_o,
  output logic [1:0]                        ForwardBE_o,
  output logic                              MemTimeout_o,
  output logic [CNT_WIDTH-1:0]              WaitCount_o
);

  mem_state_t           r_state;
  mem_state_t           w_state_nxt;
  logic [CNT_WIDTH-1:0] r_count;
  logic [CNT_WIDTH-1:0] w_count_nxt;
  logic                 w_lduse;
  logic                 w_memstall;

  forward_unit #(.REGISTER_ADDRESS_WIDTH(REGISTER_ADDRESS_WIDTH)) u_fwd_a (
    .RsE_i       (Rs1E_i),
    .RdM_i       (RdM_i),
    .RdW_i       (RdW_i),
    .RegWriteM_i (RegWriteM_i),
    .RegWriteW_i (RegWriteW_i),
    .Forward_o   (ForwardAE_o)
  );

  forward_unit #(.REGISTER_ADDRESS_WIDTH(REGISTER_ADDRESS_WIDTH)) u_fwd_b (
    .RsE_i       (Rs2E_i),
    .RdM_i       (RdM_i),
    .RdW_i       (RdW_i),
    .RegWriteM_i (RegWriteM_i),
    .RegWriteW_i (RegWriteW_i),
    .Forward_o   (ForwardBE_o)
  );

  assign w_lduse = (ResultSrcE_i == RESULT_LOAD) && (RdE_i != '0) &&
                   ((RdE_i == Rs1D_i) || (RdE_i == Rs2D_i));

  assign w_memstall = ((r_state == IDLE) && MemReqM_i && !MemReadyM_i) ||
                      (r_state == WAIT) || (r_state == ERROR);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    case (r_state)
      IDLE: begin
        if (MemReqM_i && !MemReadyM_i) begin
          w_state_nxt = WAIT;
          w_count_nxt = CNT_WIDTH'(1);
        end
      end
      WAIT: begin
        // a dropped request is treated like ready so the FSM cannot get stuck
        if (MemReadyM_i || !MemReqM_i) begin
          w_state_nxt = IDLE;
          w_count_nxt = '0;
        end else begin
          w_count_nxt = r_count + CNT_WIDTH'(1);
          if (r_count == CNT_WIDTH'(MAX_WAIT - 1)) w_state_nxt = ERROR;
        end
      end
      ERROR: begin
        w_state_nxt = ERROR;
      end
      default: begin
        w_state_nxt = IDLE;
        w_count_nxt = '0;
      end
    endcase
  end

  // clr wins over en inside the stage registers, so a freeze keeps D/E clears low
  always_comb begin
    EnF_o  = 1'b1;
    EnD_o  = 1'b1;
    EnE_o  = 1'b1;
    EnM_o  = 1'b1;
    ClrD_o = 1'b0;
    ClrE_o = 1'b0;
    ClrW_o = 1'b0;
    if (w_memstall) begin
      EnF_o  = 1'b0;
      EnD_o  = 1'b0;
      EnE_o  = 1'b0;
      EnM_o  = 1'b0;
      ClrW_o = 1'b1;
    end else if (PCSrcE_i) begin
      ClrD_o = 1'b1;
      ClrE_o = 1'b1;
    end else if (w_lduse) begin
      EnF_o  = 1'b0;
      EnD_o  = 1'b0;
      ClrE_o = 1'b1;
    end
  end

  assign MemTimeout_o = (r_state == ERROR);
  assign WaitCount_o  = r_count;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomised and directed bench for hazard_ctrl against a behavioural model.
module tb_hazard_ctrl;

  localparam int MAX_WAIT  = 16;
  localparam int CNT_WIDTH = 5;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [4:0] Rs1D_i = '0, Rs2D_i = '0, Rs1E_i = '0, Rs2E_i = '0;
  logic [4:0] RdE_i = '0, RdM_i = '0, RdW_i = '0;
  logic       RegWriteM_i = 1'b0, RegWriteW_i = 1'b0;
  logic [1:0] ResultSrcE_i = '0;
  logic       PCSrcE_i = 1'b0, MemReqM_i = 1'b0, MemReadyM_i = 1'b0;
  logic       EnF_o, EnD_o, EnE_o, EnM_o, ClrD_o, ClrE_o, ClrW_o;
  logic [1:0] ForwardAE_o, ForwardBE_o;
  logic       MemTimeout_o;
  logic [CNT_WIDTH-1:0] WaitCount_o;

  int n_chk = 0;
  int n_err = 0;

  // model state: length of current memory wait and sticky timeout
  int m_wait = 0;
  bit m_tmo  = 1'b0;

  hazard_ctrl #(.REGISTER_ADDRESS_WIDTH(5), .MAX_WAIT(MAX_WAIT), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .Rs1D_i(Rs1D_i), .Rs2D_i(Rs2D_i), .Rs1E_i(Rs1E_i), .Rs2E_i(Rs2E_i),
    .RdE_i(RdE_i), .RdM_i(RdM_i), .RdW_i(RdW_i),
    .RegWriteM_i(RegWriteM_i), .RegWriteW_i(RegWriteW_i),
    .ResultSrcE_i(ResultSrcE_i), .PCSrcE_i(PCSrcE_i),
    .MemReqM_i(MemReqM_i), .MemReadyM_i(MemReadyM_i),
    .EnF_o(EnF_o), .EnD_o(EnD_o), .EnE_o(EnE_o), .EnM_o(EnM_o),
    .ClrD_o(ClrD_o), .ClrE_o(ClrE_o), .ClrW_o(ClrW_o),
    .ForwardAE_o(ForwardAE_o), .ForwardBE_o(ForwardBE_o),
    .MemTimeout_o(MemTimeout_o), .WaitCount_o(WaitCount_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int exp_fwd(input logic [4:0] rs);
    if (RegWriteM_i && RdM_i != 0 && RdM_i == rs) return 2;
    if (RegWriteW_i && RdW_i != 0 && RdW_i == rs) return 1;
    return 0;
  endfunction

  // control word order: EnF EnD EnE EnM ClrD ClrE ClrW
  task automatic check_outputs(input string tag);
    bit   lduse, stall;
    logic [6:0] ctl;
    lduse = (ResultSrcE_i == 2'b01) && RdE_i != 0 && (RdE_i == Rs1D_i || RdE_i == Rs2D_i);
    stall = m_tmo || m_wait > 0 || (MemReqM_i && !MemReadyM_i);
    if (stall)         ctl = 7'b0000_001;
    else if (PCSrcE_i) ctl = 7'b1111_110;
    else if (lduse)    ctl = 7'b0011_010;
    else               ctl = 7'b1111_000;
    chk_val({tag, ".ctl"}, 32'({EnF_o, EnD_o, EnE_o, EnM_o, ClrD_o, ClrE_o, ClrW_o}), 32'(ctl));
    chk_val({tag, ".fwda"}, 32'(ForwardAE_o), 32'(exp_fwd(Rs1E_i)));
    chk_val({tag, ".fwdb"}, 32'(ForwardBE_o), 32'(exp_fwd(Rs2E_i)));
    chk_val({tag, ".tmo"}, 32'(MemTimeout_o), 32'(m_tmo));
    chk_val({tag, ".wcnt"}, 32'(WaitCount_o), 32'(m_wait));
  endtask

  task automatic model_update();
    if (m_tmo) return;
    if (m_wait == 0) begin
      if (MemReqM_i && !MemReadyM_i) m_wait = 1;
    end else if (!MemReqM_i || MemReadyM_i) begin
      m_wait = 0;
    end else begin
      m_wait++;
      if (m_wait == MAX_WAIT) m_tmo = 1'b1;
    end
  endtask

  // called 1 time unit after a rising edge with inputs already applied
  task automatic step(input string tag);
    #3;
    check_outputs(tag);
    @(posedge clk_i);
    model_update();
    #1;
  endtask

  task automatic pulse_reset(input string tag);
    rst_i = 1'b1;
    m_wait = 0;
    m_tmo  = 1'b0;
    #2;
    check_outputs(tag);
    rst_i = 1'b0;
    @(posedge clk_i);
    model_update();
    #1;
  endtask

  task automatic clear_inputs();
    {Rs1D_i, Rs2D_i, Rs1E_i, Rs2E_i, RdE_i, RdM_i, RdW_i} = '0;
    {RegWriteM_i, RegWriteW_i, PCSrcE_i, MemReqM_i, MemReadyM_i} = '0;
    ResultSrcE_i = '0;
  endtask

  initial begin
    #4;
    check_outputs("reset");
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    // forwarding: M wins over W, and x0 in M falls back to W
    RdM_i = 5; RegWriteM_i = 1; RdW_i = 5; RegWriteW_i = 1; Rs1E_i = 5; Rs2E_i = 5;
    step("fwd_m");
    chk_val("fwd_m_direct", 32'(ForwardAE_o), 32'd2);
    RdM_i = 0;
    step("fwd_w");
    chk_val("fwd_w_direct", 32'(ForwardAE_o), 32'd1);
    clear_inputs();

    // load-use: one bubble then default
    ResultSrcE_i = 2'b01; RdE_i = 3; Rs2D_i = 3;
    step("lduse");
    clear_inputs();
    step("lduse_after");

    // branch overrides load-use
    ResultSrcE_i = 2'b01; RdE_i = 3; Rs1D_i = 3; PCSrcE_i = 1;
    step("br_lduse");
    clear_inputs();

    // memory wait: ready low 3 cycles then high
    MemReqM_i = 1; MemReadyM_i = 0;
    repeat (3) step("mwait");
    MemReadyM_i = 1;
    step("mwait_rdy");
    chk_val("mwait_cnt_end", 32'(WaitCount_o), 32'd0);
    MemReqM_i = 0; MemReadyM_i = 0;
    step("mwait_resume");

    // watchdog timeout, ready after error is ignored
    MemReqM_i = 1; MemReadyM_i = 0;
    repeat (MAX_WAIT) step("tmo_run");
    chk_val("tmo_set", 32'(MemTimeout_o), 32'd1);
    MemReadyM_i = 1;
    repeat (3) step("tmo_hold");
    clear_inputs();
    step("tmo_idle_in");
    pulse_reset("tmo_rst");
    step("tmo_cleared");

    // reset in the middle of a wait with count 4
    MemReqM_i = 1; MemReadyM_i = 0;
    repeat (4) step("rstw_run");
    chk_val("rstw_cnt4", 32'(WaitCount_o), 32'd4);
    MemReqM_i = 0;
    pulse_reset("rstw_rst");
    step("rstw_after");

    // randomised traffic
    for (int i = 0; i < 400; i++) begin
      Rs1D_i = 5'($urandom_range(0, 3)); Rs2D_i = 5'($urandom_range(0, 3));
      Rs1E_i = 5'($urandom_range(0, 3)); Rs2E_i = 5'($urandom_range(0, 3));
      RdE_i  = 5'($urandom_range(0, 3)); RdM_i  = 5'($urandom_range(0, 3));
      RdW_i  = 5'($urandom_range(0, 3));
      RegWriteM_i  = 1'($urandom_range(0, 1));
      RegWriteW_i  = 1'($urandom_range(0, 1));
      ResultSrcE_i = 2'($urandom_range(0, 3));
      PCSrcE_i     = ($urandom_range(0, 5) == 0);
      if (m_wait == 0) MemReqM_i = ($urandom_range(0, 3) == 0);
      else             MemReqM_i = ($urandom_range(0, 9) != 0);
      MemReadyM_i  = ($urandom_range(0, 9) < 7);
      step("rand");
      if (m_tmo) begin
        clear_inputs();
        pulse_reset("rand_rst");
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
